// File: rtl/instruction_fetch_unit.sv
// Fetch stage: samples the PC, issues one instruction-memory read at a time,
// and buffers {pc, instr} in a small FIFO for decode (valid/ready). A flush
// drops the buffer and any in-flight response.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   pc_in / pc_step     current PC in; one-cycle pulse when it was consumed
//   flush               discard all fetched-but-undecoded state
//   imem_req/addr       word read request, held until imem_rvalid
//   imem_rvalid/rdata   read response
//   if_valid/pc/instr   FIFO head presented to decode
//   id_ready            decode accepts the head entry
module instruction_fetch_unit #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_in,
  output logic              pc_step,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  input  logic              id_ready
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic               pc_step_q, pc_step_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_mem_q    [FIFO_DEPTH];
  logic [31:0]        pc_mem_d    [FIFO_DEPTH];
  logic [31:0]        instr_mem_q [FIFO_DEPTH];
  logic [31:0]        instr_mem_d [FIFO_DEPTH];
  logic               push;
  logic               pop;

  // Head of the buffer is read straight out of the storage registers.
  assign if_valid  = (count_q != '0);
  assign if_pc     = pc_mem_q[rd_ptr_q];
  assign if_instr  = instr_mem_q[rd_ptr_q];
  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign pc_step   = pc_step_q;

  assign pop = if_valid && id_ready && !flush;

  // Request FSM and FIFO next-state.
  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    req_pc_d    = req_pc_q;
    pc_step_d   = 1'b0;
    push        = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    case (state_q)
      S_IDLE: begin
        // Nothing is in flight here, so the buffer count alone bounds issue.
        if (!flush && (count_q < CNT_W'(FIFO_DEPTH))) begin
          imem_req_d  = 1'b1;
          imem_addr_d = pc_in[ADDR_W+1:2];
          req_pc_d    = pc_in;
          pc_step_d   = 1'b1;
          state_d     = S_WAIT;
        end else begin
          imem_req_d  = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          imem_req_d = 1'b0;
          push       = !flush;
          state_d    = S_IDLE;
        end else if (flush) begin
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Response belongs to a squashed fetch; swallow it.
        if (imem_rvalid) begin
          imem_req_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        imem_req_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = req_pc_q;
        instr_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      req_pc_q    <= '0;
      pc_step_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      req_pc_q    <= req_pc_d;
      pc_step_q   <= pc_step_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a PC model, an instruction
// memory with programmable latency, and a scoreboard of expected {pc, instr}.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_step;
  logic        flush;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          chk = 0;
  int          err = 0;
  int          cyc = 0;
  int          last_pop = -1;
  int          n_pop = 0;
  logic        gap_check = 1'b0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] flush_target = '0;

  instruction_fetch_unit #(.ADDR_W(10), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .pc_step    (pc_step),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .id_ready   (id_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: word = 0xC0DE0000 | word address, after mem_lat cycles.
  always @(negedge clk) begin
    if (reset || !imem_req) begin
      mem_cnt     = 0;
      imem_rvalid = 1'b0;
    end else if (imem_rvalid) begin
      mem_cnt     = 0;
      imem_rvalid = 1'b0;
    end else begin
      mem_cnt = mem_cnt + 1;
      if (mem_cnt >= mem_lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hC0DE_0000 | 32'(imem_addr);
      end
    end
  end

  // Scoreboard monitor: compare on every accepted handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && if_valid && id_ready && !flush) begin
      chk++;
      if (exp_q.size() == 0) begin
        err++;
        $display("FAIL unexpected_pop actual pc=%h instr=%h expected no entry", if_pc, if_instr);
      end else begin
        e = exp_q.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          err++;
          $display("FAIL pop_entry actual pc=%h instr=%h expected pc=%h instr=%h",
                   if_pc, if_instr, e.pc, e.instr);
        end
      end
      if (gap_check && last_pop >= 0) begin
        chk++;
        if (cyc - last_pop < 2) begin
          err++;
          $display("FAIL pop_gap actual=%0d expected>=2", cyc - last_pop);
        end
      end
      last_pop = cyc;
      n_pop++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  // One clock: PC model follows flush (priority) or pc_step, zero in reset.
  task automatic tick();
    logic st;
    logic fl;
    @(posedge clk);
    st = pc_step;
    fl = flush;
    #1;
    if (reset)   pc_in = '0;
    else if (fl) pc_in = flush_target;
    else if (st) pc_in = pc_in + 32'd4;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!imem_req && n < 50);
    if (!imem_req) begin
      chk++;
      err++;
      $display("FAIL %s timeout actual imem_req=0 expected 1", name);
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk++;
      err++;
      $display("FAIL %s timeout actual pending=%0d expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    int late_steps;
    int late_req;
    int steps;
    int n;

    reset = 1'b1; pc_in = '0; flush = 1'b0; id_ready = 1'b1;
    tick(); tick();
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_pc_step", 32'(pc_step), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);

    // 1: sequential fetch at 1-cycle latency
    expect_entry(32'h0, 32'hC0DE_0000);
    expect_entry(32'h4, 32'hC0DE_0001);
    expect_entry(32'h8, 32'hC0DE_0002);
    reset = 1'b0;
    gap_check = 1'b1;
    wait_empty("t1_drain");
    id_ready  = 1'b0;
    gap_check = 1'b0;

    // 2: decode stalled, buffer fills to depth and fetch stops
    late_steps = 0;
    late_req   = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 4 && pc_step)  late_steps++;
      if (i >= 4 && imem_req) late_req++;
    end
    check("t2_late_pc_step", 32'(late_steps), 32'd0);
    check("t2_late_req", 32'(late_req), 32'd0);
    check("t2_if_valid", 32'(if_valid), 32'd1);
    check("t2_head_pc", if_pc, 32'h0000_000C);
    check("t2_head_instr", if_instr, 32'hC0DE_0003);
    check("t2_pc_in", pc_in, 32'h0000_0014);
    expect_entry(32'h0C, 32'hC0DE_0003);
    expect_entry(32'h10, 32'hC0DE_0004);
    expect_entry(32'h14, 32'hC0DE_0005);
    mem_lat  = 3;
    id_ready = 1'b1;

    // 3: 3-cycle latency, request held with stable address
    wait_req("t3_req");
    steps = 0;
    for (int k = 0; k < 4; k++) begin
      if (pc_step) steps++;
      if (k < 3) begin
        check("t3_req_high", 32'(imem_req), 32'd1);
        check("t3_addr_stable", 32'(imem_addr), 32'd5);
      end else begin
        check("t3_req_low", 32'(imem_req), 32'd0);
      end
      if (k < 3) tick();
    end
    check("t3_pc_steps", 32'(steps), 32'd1);

    // 4: flush while waiting, response lands in DRAIN two cycles later
    wait_req("t4_req");
    check("t4_addr", 32'(imem_addr), 32'd6);
    flush = 1'b1; flush_target = 32'h40; id_ready = 1'b0;
    tick();
    check("t4_drain_req", 32'(imem_req), 32'd1);
    check("t4_drain_valid", 32'(if_valid), 32'd0);
    tick();
    flush = 1'b0;
    check("t4_drain_req2", 32'(imem_req), 32'd1);
    tick();
    check("t4_done_req", 32'(imem_req), 32'd0);
    check("t4_done_valid", 32'(if_valid), 32'd0);
    wait_req("t4_refetch");
    check("t4_new_addr", 32'(imem_addr), 32'h10);

    // 5: flush coincident with response while one entry is buffered
    n = 0;
    while (!(if_valid && imem_req) && n < 50) begin
      tick();
      n++;
    end
    check("t5_buf_valid", 32'(if_valid && imem_req), 32'd1);
    check("t5_buf_pc", if_pc, 32'h40);
    check("t5_buf_instr", if_instr, 32'hC0DE_0010);
    check("t5_inflight_addr", 32'(imem_addr), 32'h11);
    tick(); tick();
    flush = 1'b1; flush_target = 32'h80; id_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_valid_cleared", 32'(if_valid), 32'd0);
    check("t5_req_cleared", 32'(imem_req), 32'd0);
    expect_entry(32'h80, 32'hC0DE_0020);
    wait_empty("t5_target");

    // 6: reset while a request is outstanding
    id_ready = 1'b0;
    wait_req("t6_req");
    reset = 1'b1;
    tick();
    check("t6_imem_req", 32'(imem_req), 32'd0);
    check("t6_imem_addr", 32'(imem_addr), 32'd0);
    check("t6_pc_step", 32'(pc_step), 32'd0);
    check("t6_if_valid", 32'(if_valid), 32'd0);
    check("t6_if_pc", if_pc, 32'd0);
    check("t6_if_instr", if_instr, 32'd0);
    reset = 1'b0; mem_lat = 1; id_ready = 1'b1;
    expect_entry(32'h0, 32'hC0DE_0000);
    expect_entry(32'h4, 32'hC0DE_0001);
    wait_empty("t6_restart");
    id_ready = 1'b0;
    tick(); tick(); tick();
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
